window_gen3x3: RTL

WINDOW_GEN3X3 -- requirements
Module: window_gen3x3

---
 rtl/win_pkg.sv | 32 +++
 rtl/line_ram.sv | 37 +++
 rtl/window_gen3x3.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/win_pkg.sv
// -----------------------------------------------------------------------------
// win_pkg
// Shared constants and types for the 3x3 window generator.
//   PIX_W  : bits per pixel
//   KSIZE  : window edge length
//   WIN_W  : packed window width (KSIZE*KSIZE pixels)
//   state_t: window generator control states
//   ptr_back: modulo-3 step back for the circular line-buffer pointer
// -----------------------------------------------------------------------------
package win_pkg;

    localparam int PIX_W = 8;
    localparam int KSIZE = 3;
    localparam int WIN_W = PIX_W * KSIZE * KSIZE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    // (ptr - k) mod 3 for ptr, k in 0..2
    function automatic logic [1:0] ptr_back(input logic [1:0] ptr, input logic [1:0] k);
        logic [2:0] t;
        t = {1'b0, ptr} + 3'd3 - {1'b0, k};
        if (t >= 3'd3) begin
            t = t - 3'd3;
        end
        return t[1:0];
    endfunction

endpackage

// File: rtl/line_ram.sv
// -----------------------------------------------------------------------------
// line_ram
// One video line of storage: DEPTH x PIX_W, one synchronous write port and one
// combinational read port. Contents are not cleared by reset.
// Ports:
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address (column)
//   i_wdata  : write pixel
//   i_raddr  : read address (column)
//   o_rdata  : read pixel (combinational)
// -----------------------------------------------------------------------------
module line_ram
    import win_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [PIX_W-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/window_gen3x3.sv
// -----------------------------------------------------------------------------
// window_gen3x3
// Turns a raster pixel stream into 3x3 windows. Three circular line buffers
// hold the current line (written) and the two previous lines (read at the same
// column); a 3x3 register window shifts left on each accepted pixel.
// Only full interior windows are emitted, one strobe per window.
// Ports:
//   clk            : clock
//   rst            : synchronous active-high reset
//   pixel_in       : raster-order pixel
//   pixel_in_valid : pixel accepted whenever high (no backpressure)
//   pixel_data     : 3x3 window, byte 3*r+c, r=0 oldest line, c=0 leftmost
//   is_valid_pdata : one-cycle strobe per new window
//   frame_done     : (only with WINGEN_FRAME_DONE_EN) one-cycle pulse on the
//                    cycle after the last pixel of a frame is accepted
// Build option: define WINGEN_FRAME_DONE_EN to add the frame_done port.
// -----------------------------------------------------------------------------
module window_gen3x3
    import win_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             pixel_in_valid,
    output logic [WIN_W-1:0] pixel_data,
    output logic             is_valid_pdata
`ifdef WINGEN_FRAME_DONE_EN
    ,
    output logic             frame_done
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam int NPIX = KSIZE * KSIZE;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [1:0]       r_wr_sel;        // buffer receiving the current line
    logic             r_last_seen;     // frame's last pixel accepted last cycle
    logic             r_valid;
    logic [WIN_W-1:0] r_pixel_data;
    logic [PIX_W-1:0] r_win      [NPIX];
    logic [PIX_W-1:0] w_win_next [NPIX];
    logic [WIN_W-1:0] w_pack;
    logic [PIX_W-1:0] w_rd       [KSIZE];
    logic [1:0]       w_sel_m1;
    logic [1:0]       w_sel_m2;
    logic             w_accept;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_frame_last;
    logic             w_win_hit;

    // Reset takes priority over an incoming pixel.
    assign w_accept     = pixel_in_valid & ~rst;
    assign w_col_last   = (r_col == COL_LAST);
    assign w_row_last   = (r_row == ROW_LAST);
    assign w_frame_last = w_col_last & w_row_last;
    // Rows 0/1 of a frame are only ever read once row>=2, by which point they
    // were rewritten in this frame, so stale lines never reach a window.
    assign w_win_hit    = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_sel_m1     = ptr_back(r_wr_sel, 2'd1);
    assign w_sel_m2     = ptr_back(r_wr_sel, 2'd2);

    genvar gi;
    generate
        for (gi = 0; gi < KSIZE; gi++) begin : g_lb
            line_ram #(
                .DEPTH (IMG_WIDTH)
            ) u_line_ram (
                .clk     (clk),
                .i_we    (w_accept && (r_wr_sel == 2'(gi))),
                .i_waddr (r_col),
                .i_wdata (pixel_in),
                .i_raddr (r_col),
                .o_rdata (w_rd[gi])
            );
        end

        // Shift each window row left; the new right column is
        // {line(row-2), line(row-1), pixel_in}.
        for (gi = 0; gi < KSIZE; gi++) begin : g_shift
            assign w_win_next[gi*KSIZE + 0] = r_win[gi*KSIZE + 1];
            assign w_win_next[gi*KSIZE + 1] = r_win[gi*KSIZE + 2];
        end
        assign w_win_next[2] = w_rd[w_sel_m2];
        assign w_win_next[5] = w_rd[w_sel_m1];
        assign w_win_next[8] = pixel_in;

        for (gi = 0; gi < NPIX; gi++) begin : g_pack
            assign w_pack[gi*PIX_W +: PIX_W] = w_win_next[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_wr_sel     <= 2'd0;
            r_last_seen  <= 1'b0;
            r_valid      <= 1'b0;
            r_pixel_data <= '0;
            for (int i = 0; i < NPIX; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_valid     <= w_accept && w_win_hit;
            r_last_seen <= w_accept && w_frame_last;
            if (w_accept) begin
                r_win <= w_win_next;
                // Output holds between windows; only interior windows load it.
                if (w_win_hit) begin
                    r_pixel_data <= w_pack;
                end
                if (w_col_last) begin
                    r_col    <= '0;
                    r_wr_sel <= (r_wr_sel == 2'd2) ? 2'd0 : r_wr_sel + 2'd1;
                    r_row    <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                if (w_accept && w_col_last && (r_row == RW'(1))) begin
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                // Cycle after the frame's last pixel: a new pixel means the
                // next frame has started back-to-back.
                if (r_last_seen) begin
                    w_state_next = w_accept ? FILL : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign pixel_data     = r_pixel_data;
    assign is_valid_pdata = r_valid;
`ifdef WINGEN_FRAME_DONE_EN
    assign frame_done     = r_last_seen;
`endif

endmodule
